// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit feeding HI/LO.
// Multiply completes in one working cycle; divide runs 32 restoring
// radix-2 iterations on magnitudes followed by a sign-fix cycle.
// Optional macro MULDIV_EARLY_OUT_EN: divides with rt=0 or |rs|<|rt|
// bypass the iteration loop and go straight to the sign-fix cycle.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic        flush_i,
   input  logic        stall_i,
   output logic        busy_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        done_o
);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t      state_q, state_d;
   logic        sgn_q, sgn_d;
   logic [31:0] rs_q, rs_d;
   logic [31:0] rt_q, rt_d;
   logic [31:0] div_q, div_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        sgn_in_w;
   logic [31:0] mag_rs_w;
   logic [31:0] mag_rt_w;
   logic [63:0] mul_a_w;
   logic [63:0] mul_b_w;
   logic [63:0] prod_w;
   logic [32:0] shift_w;
   logic        ge_w;
   logic [31:0] sub_w;
   logic [31:0] quo_fix_w;
   logic [31:0] rem_fix_w;
`ifdef MULDIV_EARLY_OUT_EN
   logic        early_w;
`endif

   // Operand magnitudes at accept time (MULT/DIV are the signed ops).
   assign sgn_in_w = ~op_i[0];
   assign mag_rs_w = (sgn_in_w && rs_i[31]) ? (32'd0 - rs_i) : rs_i;
   assign mag_rt_w = (sgn_in_w && rt_i[31]) ? (32'd0 - rt_i) : rt_i;
`ifdef MULDIV_EARLY_OUT_EN
   assign early_w  = (rt_i == 32'd0) || (mag_rs_w < mag_rt_w);
`endif

   // Extended operands give the signed or unsigned 64-bit product directly.
   assign mul_a_w = {{32{sgn_q & rs_q[31]}}, rs_q};
   assign mul_b_w = {{32{sgn_q & rt_q[31]}}, rt_q};
   assign prod_w  = mul_a_w * mul_b_w;

   // Restoring step: when the trial subtraction succeeds the true difference
   // is below 2^32, so a 32-bit subtract is exact.
   assign shift_w = {rem_q, quo_q[31]};
   assign ge_w    = (shift_w >= {1'b0, div_q});
   assign sub_w   = shift_w[31:0] - div_q;

   // Sign correction: quotient negative on differing signs, remainder follows dividend.
   assign quo_fix_w = (sgn_q && (rs_q[31] ^ rt_q[31])) ? (32'd0 - quo_q) : quo_q;
   assign rem_fix_w = (sgn_q && rs_q[31]) ? (32'd0 - rem_q) : rem_q;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sgn_q   <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         div_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         sgn_q   <= sgn_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Next-state, datapath update and busy/done generation.
   always_comb begin
      state_d = state_q;
      sgn_d   = sgn_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      div_d   = div_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               busy_o  = 1'b1;
               sgn_d   = sgn_in_w;
               rs_d    = rs_i;
               rt_d    = rt_i;
               count_d = '0;
               if (op_i[1]) begin
                  div_d   = mag_rt_w;
                  quo_d   = mag_rs_w;
                  rem_d   = '0;
                  state_d = DIV;
`ifdef MULDIV_EARLY_OUT_EN
                  if (early_w) begin
                     quo_d   = '0;
                     rem_d   = mag_rs_w;
                     state_d = FIX;
                  end
`endif
               end else begin
                  state_d = MUL;
               end
            end
         end
         MUL: begin
            busy_o  = 1'b1;
            hi_d    = prod_w[63:32];
            lo_d    = prod_w[31:0];
            state_d = DONE;
         end
         DIV: begin
            busy_o  = 1'b1;
            rem_d   = ge_w ? sub_w : shift_w[31:0];
            quo_d   = {quo_q[30:0], ge_w};
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) begin
               state_d = FIX;
            end
         end
         FIX: begin
            busy_o  = 1'b1;
            state_d = DONE;
            if (rt_q == 32'd0) begin
               hi_d = rs_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix_w;
               lo_d = quo_fix_w;
            end
         end
         DONE: begin
            done_o = 1'b1;
            if (!stall_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Flush abandons whatever is in flight and leaves HI/LO untouched.
      if (flush_i) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         busy_o  = 1'b0;
         done_o  = 1'b0;
      end

      if (rst) begin
         busy_o = 1'b0;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table vectors, model-checked random
// operations, and hand sequences for flush, stall-in-DONE and mid-op reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] rs_i;
   logic [31:0] rt_i;
   logic        flush_i;
   logic        stall_i;
   logic        busy_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        done_o;

   muldiv_unit dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .op_i    (op_i),
      .rs_i    (rs_i),
      .rt_i    (rt_i),
      .flush_i (flush_i),
      .stall_i (stall_i),
      .busy_o  (busy_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o),
      .done_o  (done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      string       tag;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference results built from native SV arithmetic.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint          sa64, sb64, sp;
      longint unsigned ua64, ub64, up;
      int              sa, sbv;
      hi = '0;
      lo = '0;
      case (op)
         2'd0: begin
            sa64 = longint'($signed(a));
            sb64 = longint'($signed(b));
            sp   = sa64 * sb64;
            hi   = sp[63:32];
            lo   = sp[31:0];
         end
         2'd1: begin
            ua64 = {32'd0, a};
            ub64 = {32'd0, b};
            up   = ua64 * ub64;
            hi   = up[63:32];
            lo   = up[31:0];
         end
         2'd2: begin
            if (b == 32'd0) begin
               hi = a;
               lo = 32'hFFFFFFFF;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               hi = 32'd0;
               lo = 32'h80000000;
            end else begin
               sa  = a;
               sbv = b;
               lo  = sa / sbv;
               hi  = sa % sbv;
            end
         end
         default: begin
            if (b == 32'd0) begin
               hi = a;
               lo = 32'hFFFFFFFF;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      logic [31:0] ma, mb;
`endif
      if (!op[1]) return 2;
`ifdef MULDIV_EARLY_OUT_EN
      ma = (!op[0] && a[31]) ? (32'd0 - a) : a;
      mb = (!op[0] && b[31]) ? (32'd0 - b) : b;
      if (b == 32'd0 || ma < mb) return 2;
`else
      if (a === 32'hx || b === 32'hx) return 0;
`endif
      return 34;
   endfunction

   // Drive a start at the current time, confirm it is taken, advance to the accept edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      start_i = 1'b1;
      op_i    = op;
      rs_i    = a;
      rt_i    = b;
      #1;
      chk1({tag, ".accept_busy"}, busy_o, 1'b1);
      @(posedge clk);
   endtask

   task automatic run_op(input bit sync, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input string tag);
      exp_t e;
      int   k;
      bit   got;
      if (!sync) @(negedge clk);
      e.hi  = ehi;
      e.lo  = elo;
      e.lat = exp_lat(op, a, b);
      e.tag = tag;
      sb.push_back(e);
      issue(op, a, b, tag);
      k   = 0;
      got = 1'b0;
      while (!got && k < 60) begin
         @(negedge clk);
         start_i = 1'b0;
         k++;
         #1;
         if (done_o) got = 1'b1;
         else chk1({tag, ".busy"}, busy_o, 1'b1);
      end
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL %s.timeout: done_o not seen within 60 cycles", tag);
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s.scoreboard: done_o with no expected entry", tag);
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".hi"}, hi_o, e.hi);
         chk({e.tag, ".lo"}, lo_o, e.lo);
         chk({e.tag, ".latency"}, 32'(k), 32'(e.lat));
         chk1({e.tag, ".done_busy"}, busy_o, 1'b0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[13];
      logic [1:0]  rop;
      logic [31:0] ra, rb, mhi, mlo;
      int          k;

      tbl[0]  = '{2'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg"};
      tbl[1]  = '{2'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, "multu"};
      tbl[2]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
      tbl[3]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"};
      tbl[4]  = '{2'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "divu_by0"};
      tbl[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "div_ovf"};
      tbl[6]  = '{2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0_neg"};
      tbl[7]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7_m2"};
      tbl[8]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min"};
      tbl[9]  = '{2'd3, 32'd3,        32'd10,       32'd3,        32'd0,        "divu_small"};
      tbl[10] = '{2'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, "divu_max_1"};
      tbl[11] = '{2'd2, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       "div_m100_m7"};
      tbl[12] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};

      rst     = 1'b1;
      start_i = 1'b0;
      op_i    = 2'd0;
      rs_i    = '0;
      rt_i    = '0;
      flush_i = 1'b0;
      stall_i = 1'b0;

      #12;
      chk1("reset.busy", busy_o, 1'b0);
      chk1("reset.done", done_o, 1'b0);
      chk("reset.hi", hi_o, 32'd0);
      chk("reset.lo", lo_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].tag);
      end

      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 2 == 1) ? 32'($urandom_range(1, 50)) : $urandom;
         model(rop, ra, rb, mhi, mlo);
         run_op(1'b0, rop, ra, rb, mhi, mlo, $sformatf("rand%0d", i));
      end

      // Flush a running divide at cycle 10, then start anew at cycle 11.
      @(negedge clk);
      issue(2'd2, 32'd1000, 32'd3, "flush");
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (k == 10) flush_i = 1'b1;
         #1;
         chk1($sformatf("flush.done_c%0d", k), done_o, 1'b0);
         chk1($sformatf("flush.busy_c%0d", k), busy_o, (k < 10));
      end
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      chk1("flush.idle_done", done_o, 1'b0);
      chk1("flush.idle_busy", busy_o, 1'b0);
      run_op(1'b1, 2'd1, 32'd6, 32'd7, 32'd0, 32'd42, "after_flush");

      // Stall holds DONE for five cycles with start still asserted.
      @(negedge clk);
      stall_i = 1'b1;
      issue(2'd1, 32'h00010000, 32'h00030000, "stall");
      for (k = 1; k <= 6; k++) begin
         @(negedge clk);
         #1;
         if (k == 1) begin
            chk1("stall.busy_c1", busy_o, 1'b1);
            chk1("stall.done_c1", done_o, 1'b0);
         end else begin
            chk1($sformatf("stall.done_c%0d", k), done_o, 1'b1);
            chk1($sformatf("stall.busy_c%0d", k), busy_o, 1'b0);
            chk($sformatf("stall.hi_c%0d", k), hi_o, 32'h00000003);
            chk($sformatf("stall.lo_c%0d", k), lo_o, 32'h00000000);
         end
      end
      stall_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      #1;
      chk1("stall.release_done", done_o, 1'b0);
      chk1("stall.release_busy", busy_o, 1'b0);

      // Reset mid-divide clears outputs at once; accept right at release.
      run_op(1'b0, 2'd0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, "pre_rst");
      @(negedge clk);
      issue(2'd2, 32'h12345678, 32'h00000011, "rst_div");
      for (k = 1; k < 15; k++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      @(negedge clk);
      rst     = 1'b1;
      start_i = 1'b1;
      #1;
      chk("rst_mid.hi", hi_o, 32'd0);
      chk("rst_mid.lo", lo_o, 32'd0);
      chk1("rst_mid.done", done_o, 1'b0);
      chk1("rst_mid.busy", busy_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      run_op(1'b1, 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "post_rst");

      chk("scoreboard.empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 start_i  in  1  EXE holds a valid MULT/MULTU/DIV/DIVU instruction.
REQ-004 op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled only on accepted start.
REQ-005 rs_i, rt_i  in  32 each  operands; rs dividend/multiplicand, rt divisor/multiplier; sampled only on accepted start.
REQ-006 flush_i  in  1  exception flush of EXE; aborts the operation in progress.
REQ-007 stall_i  in  1  pipeline frozen this cycle (cache busy); EXE/MEM not advancing.
REQ-008 busy_o  out  1  drives the hazard controller's DIVMULTBusy; 1 stalls PC, IF/ID, ID/EXE.
REQ-009 hi_o, lo_o  out  32 each  result for HI/LO write; valid while done_o=1.
REQ-010 done_o  out  1  result held and valid.

Function
REQ-011 The FSM SHALL have states IDLE, MUL, DIV, FIX, DONE.
REQ-012 Accept: IDLE & start_i & !flush_i SHALL latch op/operands; MULx -> MUL, DIVx -> DIV with count=0.
REQ-013 MUL SHALL form the 64-bit product (signed for MULT, unsigned for MULTU) and go to DONE next cycle.
REQ-014 DIV SHALL run 32 restoring radix-2 iterations on 32-bit magnitudes, count 0..31, then go to FIX.
REQ-015 FIX SHALL apply signs: DIV quotient negated when operand signs differ; remainder takes dividend sign; DIVU unchanged; then DONE.
REQ-016 Results: hi=product[63:32]/remainder, lo=product[31:0]/quotient; registered, stable in DONE.
REQ-017 Divisor zero SHALL yield lo=32'hFFFFFFFF, hi=rs (unsigned: raw rs; signed: sign fix per REQ-015 on |rs|); no exception raised.
REQ-018 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-019 busy_o SHALL be combinational: 1 when (IDLE & start_i & !flush_i) or state is MUL, DIV or FIX; 0 in DONE, in IDLE without start, and whenever flush_i=1.
REQ-020 Latency from accept cycle (cycle 0): MUL -> DONE at cycle 2; DIV -> DONE at cycle 34; busy_o high cycles 0..1 and 0..33 respectively.
REQ-021 DONE: done_o=1; if !stall_i, next state IDLE; if stall_i, stay DONE holding hi/lo.
REQ-022 start_i still asserted in DONE (same instruction) SHALL NOT restart; a new start is accepted only from IDLE.
REQ-023 flush_i in any state SHALL force next state IDLE and discard the result; HI/LO not updated.
REQ-024 stall_i SHALL NOT pause MUL/DIV/FIX progress; it only holds DONE.
REQ-025 start_i deasserting mid-operation without flush_i SHALL be ignored; operation completes.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, count=0, hi_o=lo_o=0, done_o=0, busy_o=0, including mid-operation.
REQ-027 After rst release the first accept SHALL be possible on the first clock edge.

Configuration
REQ-028 Macro MULDIV_EARLY_OUT_EN, when defined: a DIVx with rt=0 or |rs|<|rt| (magnitudes per signedness) SHALL skip DIV and go IDLE -> FIX -> DONE (DONE at cycle 2), quotient 0 (or 0xFFFFFFFF if rt=0), remainder rs.
REQ-029 Macro undefined: every division SHALL take the full 34-cycle path of REQ-020; results are identical either way.

Verification
REQ-030 MULT rs=0xFFFFFFFE, rt=3 -> busy 2 cycles, DONE at cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x2, lo=0xFFFFFFFA.
REQ-031 DIV rs=-7 (0xFFFFFFF9), rt=2 -> DONE at cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
REQ-032 DIVU rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5; DONE at cycle 2 with MULDIV_EARLY_OUT_EN, cycle 34 without.
REQ-033 DIV running, flush_i at cycle 10 -> busy_o=0 that cycle, IDLE next, done_o never asserts; a new start at cycle 11 is accepted.
REQ-034 MULTU done with stall_i=1 for 5 cycles, start_i held -> stays DONE, busy_o=0, hi/lo stable, no restart; stall_i=0 -> IDLE next.
REQ-035 rst pulsed at cycle 15 of a DIV -> outputs zero immediately, IDLE after release.
